// File: rtl/r2w1_pkg.sv
// Shared widths, limits and load-FIFO entry layout
// for the register-file write scheduler.
package r2w1_pkg;

  localparam int DATA_WIDTH_D      = 8;
  localparam int ADDR_WIDTH_D      = 12;
  localparam int FIFO_DEPTH_BITS_D = 2;
  localparam int STARVE_LIMIT_D    = 8;

  typedef struct packed {
    logic [ADDR_WIDTH_D-1:0] addr;
    logic [DATA_WIDTH_D-1:0] data;
  } wb_entry_t;

  localparam int ENTRY_W_D = $bits(wb_entry_t);

  function automatic int entry_w(input int aw,
                                 input int dw);
    return aw + dw;
  endfunction

endpackage

// File: rtl/r2w1_write_scheduler_wb_fifo.sv
// Load-return FIFO: entries are {addr, data}; per-entry
// valid and address are exported for the pending compare.
module wb_fifo
  import r2w1_pkg::*;
#(
  parameter int AW = ADDR_WIDTH_D,
  parameter int DW = DATA_WIDTH_D,
  parameter int DB = FIFO_DEPTH_BITS_D,
  localparam int EW = entry_w(AW, DW),
  localparam int D  = 1 << DB
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_push,
  input  logic [EW-1:0]        i_wdata,
  input  logic                 i_pop,
  output logic [EW-1:0]        o_rdata,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [D-1:0]         o_vld,
  output logic [D-1:0][AW-1:0] o_addr
);

  logic [EW-1:0] r_mem [D];
  logic [DB-1:0] r_wr;
  logic [DB-1:0] r_rd;
  logic [DB:0]   r_cnt;

  assign o_full  = (r_cnt == (DB+1)'(D));
  assign o_empty = (r_cnt == '0);
  assign o_rdata = r_mem[r_rd];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (i_pop)  r_rd <= r_rd + 1'b1;
      unique case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr] <= i_wdata;
  end

  // An entry is live when its distance from the head is below the count.
  for (genvar g = 0; g < D; g++) begin : g_ent
    logic [DB-1:0] w_off;
    assign w_off       = DB'(g) - r_rd;
    assign o_vld[g]    = ({1'b0, w_off} < r_cnt);
    assign o_addr[g]   = r_mem[g][EW-1 -: AW];
  end

endmodule

// File: rtl/r2w1_write_scheduler.sv
// Single write port owner for the 2R/1W register file:
// ALU/load arbitration, starvation stall, forwarding, pending.
module r2w1_write_scheduler
  import r2w1_pkg::*;
#(
  parameter int DATA_WIDTH      = DATA_WIDTH_D,
  parameter int ADDR_WIDTH      = ADDR_WIDTH_D,
  parameter int FIFO_DEPTH_BITS = FIFO_DEPTH_BITS_D,
  parameter int STARVE_LIMIT    = STARVE_LIMIT_D
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  alu_valid,
  input  logic [ADDR_WIDTH-1:0] alu_addr,
  input  logic [DATA_WIDTH-1:0] alu_data,
  output logic                  alu_stall,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] addr_w,
  output logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] addr_r_a,
  input  logic [ADDR_WIDTH-1:0] addr_r_b,
  output logic                  fwd_a_hit,
  output logic [DATA_WIDTH-1:0] fwd_a_data,
  output logic                  fwd_b_hit,
  output logic [DATA_WIDTH-1:0] fwd_b_data,
  output logic                  pend_a,
  output logic                  pend_b
);

  localparam int EW  = entry_w(ADDR_WIDTH, DATA_WIDTH);
  localparam int D   = 1 << FIFO_DEPTH_BITS;
  localparam int WCW = $clog2(STARVE_LIMIT + 1);
  localparam logic [WCW-1:0] LIM = WCW'(STARVE_LIMIT - 1);

  logic                         w_full;
  logic                         w_empty;
  logic                         w_push;
  logic                         w_pop;
  logic                         w_alu_go;
  logic [EW-1:0]                w_head;
  logic [D-1:0]                 w_vld;
  logic [D-1:0][ADDR_WIDTH-1:0] w_addrs;
  logic [WCW-1:0]               r_wait;
  logic [WCW-1:0]               w_wait_nxt;

  assign mem_ready = !w_full;
  assign w_push    = mem_valid && !w_full;
  assign w_alu_go  = alu_valid && !alu_stall;
  assign w_pop     = !w_alu_go && !w_empty;

  wb_fifo #(
    .AW (ADDR_WIDTH),
    .DW (DATA_WIDTH),
    .DB (FIFO_DEPTH_BITS)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_wdata ({mem_addr, mem_data}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_vld   (w_vld),
    .o_addr  (w_addrs)
  );

  // Saturating count of cycles the head was passed over.
  always_comb begin
    w_wait_nxt = r_wait;
    if (w_empty || w_pop)  w_wait_nxt = '0;
    else if (r_wait != LIM) w_wait_nxt = r_wait + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wait    <= '0;
      alu_stall <= 1'b0;
    end else begin
      r_wait    <= w_wait_nxt;
      alu_stall <= (w_wait_nxt == LIM);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we      <= 1'b0;
      addr_w  <= '0;
      data_in <= '0;
    end else if (w_alu_go) begin
      we      <= 1'b1;
      addr_w  <= alu_addr;
      data_in <= alu_data;
    end else if (w_pop) begin
      we      <= 1'b1;
      addr_w  <= w_head[EW-1 -: ADDR_WIDTH];
      data_in <= w_head[DATA_WIDTH-1:0];
    end else begin
      we      <= 1'b0;
    end
  end

  // RAM reads return pre-write data; flag it one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fwd_a_hit  <= 1'b0;
      fwd_a_data <= '0;
      fwd_b_hit  <= 1'b0;
      fwd_b_data <= '0;
    end else begin
      fwd_a_hit  <= we && (addr_w == addr_r_a);
      fwd_a_data <= data_in;
      fwd_b_hit  <= we && (addr_w == addr_r_b);
      fwd_b_data <= data_in;
    end
  end

  always_comb begin
    pend_a = 1'b0;
    pend_b = 1'b0;
    for (int i = 0; i < D; i++) begin
      if (w_vld[i] && (w_addrs[i] == addr_r_a)) pend_a = 1'b1;
      if (w_vld[i] && (w_addrs[i] == addr_r_b)) pend_b = 1'b1;
    end
  end

endmodule

// File: tb/tb_r2w1_write_scheduler.sv
// Scoreboard bench for r2w1_write_scheduler: per-source
// expected-write queues plus directed timing checks.
module tb_r2w1_write_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        alu_valid;
  logic [11:0] alu_addr;
  logic [7:0]  alu_data;
  logic        alu_stall;
  logic        mem_valid;
  logic        mem_ready;
  logic [11:0] mem_addr;
  logic [7:0]  mem_data;
  logic        we;
  logic [11:0] addr_w;
  logic [7:0]  data_in;
  logic [11:0] addr_r_a;
  logic [11:0] addr_r_b;
  logic        fwd_a_hit;
  logic [7:0]  fwd_a_data;
  logic        fwd_b_hit;
  logic [7:0]  fwd_b_data;
  logic        pend_a;
  logic        pend_b;

  typedef struct {
    logic [11:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t alu_q[$];
  wr_t mem_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  r2w1_write_scheduler dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .alu_valid  (alu_valid),
    .alu_addr   (alu_addr),
    .alu_data   (alu_data),
    .alu_stall  (alu_stall),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .we         (we),
    .addr_w     (addr_w),
    .data_in    (data_in),
    .addr_r_a   (addr_r_a),
    .addr_r_b   (addr_r_b),
    .fwd_a_hit  (fwd_a_hit),
    .fwd_a_data (fwd_a_data),
    .fwd_b_hit  (fwd_b_hit),
    .fwd_b_data (fwd_b_data),
    .pend_a     (pend_a),
    .pend_b     (pend_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alu(input logic v,
                           input logic [11:0] a,
                           input logic [7:0] d);
    alu_valid = v;
    alu_addr  = a;
    alu_data  = d;
    if (v) alu_q.push_back('{a: a, d: d});
  endtask

  task automatic drain();
    int n = 0;
    while ((alu_q.size() + mem_q.size()) != 0 && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("drain", alu_q.size() + mem_q.size(), 0);
    tick();
    tick();
  endtask

  // Each write is matched to its source by address, then fully compared.
  always @(negedge clk) begin
    if (reset_n && we) begin
      if (alu_q.size() > 0 && alu_q[0].a == addr_w) begin
        chk("alu_wr", {addr_w, data_in}, {alu_q[0].a, alu_q[0].d});
        void'(alu_q.pop_front());
      end else if (mem_q.size() > 0) begin
        chk("mem_wr", {addr_w, data_in}, {mem_q[0].a, mem_q[0].d});
        void'(mem_q.pop_front());
      end else begin
        chk("unexp_wr", {addr_w, data_in}, 32'hFFFFF);
      end
    end
  end

  always @(posedge clk) begin
    if (reset_n && alu_stall) chk("alu_proto", alu_valid, 0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1);
  end

  initial begin
    int nm, acc5, npulse, stall_at, nwr;
    logic r;
    reset_n   = 1'b0;
    alu_valid = 0; alu_addr = 0; alu_data = 0;
    mem_valid = 0; mem_addr = 0; mem_data = 0;
    addr_r_a  = 12'h7FF;
    addr_r_b  = 12'h7FE;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    chk("rst_we", we, 0);
    chk("rst_addr", addr_w, 0);
    chk("rst_data", data_in, 0);
    chk("rst_fwd", {fwd_a_hit, fwd_b_hit}, 0);
    chk("rst_fwdd", {fwd_a_data, fwd_b_data}, 0);
    chk("rst_stall", alu_stall, 0);
    chk("rst_ready", mem_ready, 1);
    chk("rst_pend", {pend_a, pend_b}, 0);

    // ALU path: one-cycle latency
    drive_alu(1, 12'h005, 8'hA5);
    tick();
    drive_alu(0, 0, 0);
    chk("alu_we", we, 1);
    chk("alu_addr", addr_w, 12'h005);
    chk("alu_data", data_in, 8'hA5);
    tick();
    chk("alu_we_off", we, 0);
    chk("alu_hold", {addr_w, data_in}, {12'h005, 8'hA5});
    drain();

    // load path: two-cycle latency
    mem_valid = 1; mem_addr = 12'h101; mem_data = 8'h11;
    chk("lat_ready", mem_ready, 1);
    mem_q.push_back('{a: 12'h101, d: 8'h11});
    tick();
    mem_valid = 0;
    chk("lat_c1", we, 0);
    tick();
    chk("lat_c2", {we, addr_w}, {1'b1, 12'h101});
    drain();

    // fill: 5 loads against 6 busy ALU cycles
    nm = 0;
    acc5 = -1;
    for (int cyc = 0; cyc < 40 && !(nm == 5 && cyc >= 6); cyc++) begin
      drive_alu(cyc < 6 && !alu_stall, 12'h800 + 12'(cyc), 8'(cyc));
      mem_valid = (nm < 5);
      mem_addr  = 12'h100 + 12'(nm);
      mem_data  = 8'h50 + 8'(nm);
      r = mem_valid && mem_ready;
      tick();
      if (r) begin
        mem_q.push_back('{a: 12'h100 + 12'(nm), d: 8'h50 + 8'(nm)});
        nm++;
        if (nm == 4) chk("full_ready", mem_ready, 0);
        if (nm == 5) acc5 = cyc;
      end
    end
    mem_valid = 0;
    drive_alu(0, 0, 0);
    chk("fill_acc", nm, 5);
    chk("acc5_cyc", acc5, 7);
    drain();

    // starvation: one load behind a continuously busy ALU
    npulse = 0;
    stall_at = -1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      drive_alu(!alu_stall, 12'h840 + 12'(cyc), 8'h80 + 8'(cyc));
      mem_valid = (cyc == 0);
      mem_addr  = 12'h1A0;
      mem_data  = 8'h5A;
      if (cyc == 0) mem_q.push_back('{a: 12'h1A0, d: 8'h5A});
      tick();
      if (alu_stall) begin
        npulse++;
        stall_at = cyc;
      end
      if (cyc == 8) chk("starve_wr", {we, addr_w}, {1'b1, 12'h1A0});
    end
    mem_valid = 0;
    drive_alu(0, 0, 0);
    chk("stall_pulses", npulse, 1);
    chk("stall_cyc", stall_at, 7);
    drain();

    // forwarding
    drive_alu(1, 12'h010, 8'h3C);
    tick();
    drive_alu(0, 0, 0);
    addr_r_a = 12'h010;
    addr_r_b = 12'h011;
    tick();
    chk("fwd_a_hit", fwd_a_hit, 1);
    chk("fwd_a_data", fwd_a_data, 8'h3C);
    chk("fwd_b_hit", fwd_b_hit, 0);
    chk("fwd_b_data", fwd_b_data, 8'h3C);
    tick();
    chk("fwd_a_clr", fwd_a_hit, 0);
    drain();

    // pending flag across the pop
    addr_r_a = 12'h021;
    addr_r_b = 12'h020;
    #1;
    chk("pend_idle", pend_b, 0);
    for (int cyc = 0; cyc < 6; cyc++) begin
      drive_alu(cyc < 4 && !alu_stall, 12'h900 + 12'(cyc), 8'h90);
      mem_valid = (cyc == 0);
      mem_addr  = 12'h020;
      mem_data  = 8'h77;
      if (cyc == 0) mem_q.push_back('{a: 12'h020, d: 8'h77});
      tick();
      chk($sformatf("pend_b%0d", cyc), pend_b, (cyc < 4) ? 1 : 0);
      if (cyc == 0) chk("pend_a", pend_a, 0);
    end
    mem_valid = 0;
    drive_alu(0, 0, 0);
    drain();

    // reset with three loads buffered and a write in flight
    for (int cyc = 0; cyc < 4; cyc++) begin
      alu_valid = 1;
      alu_addr  = 12'hA00 + 12'(cyc);
      alu_data  = 8'hA0 + 8'(cyc);
      if (cyc < 3) alu_q.push_back('{a: alu_addr, d: alu_data});
      mem_valid = (cyc < 3);
      mem_addr  = 12'h130 + 12'(cyc);
      mem_data  = 8'h30;
      tick();
    end
    addr_r_a = 12'h130;
    addr_r_b = 12'h132;
    #1;
    chk("pre_rst_we", we, 1);
    chk("pre_rst_pend", {pend_a, pend_b}, 2'b11);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_we", we, 0);
    chk("mid_rst_ready", mem_ready, 1);
    chk("mid_rst_pend", {pend_a, pend_b}, 0);
    alu_valid = 0;
    mem_valid = 0;
    alu_q.delete();
    mem_q.delete();
    tick();
    tick();
    reset_n = 1'b1;
    nwr = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      tick();
      if (we) nwr++;
    end
    chk("post_rst_wr", nwr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
